fix_toe_responder: RTL
======================

FIX_TOE_RESPONDER -- requirements
Module: fix_toe_responder

Interface
REQ-001 Parameter CONNECT_LATENCY, default 3: cycles from connect acceptance to connected_o; legal 1..15.
REQ-002 Parameter FIFO_DEPTH, default 16: network ingress FIFO entries; power of two.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 connect_req_i  in  1  connect request from FIX engine.
REQ-006 connect_addr_i  in  2  host index requested.
REQ-007 disconnect_i  in  1  disconnect request from FIX engine.
REQ-008 disconnect_host_num_i  in  2  host index to disconnect.
REQ-009 send_message_valid_i  in  1  engine outbound byte valid.
REQ-010 send_message_i  in  8  engine outbound byte.
REQ-011 host_up_i  in  4  per-host availability mask.
REQ-012 net_data_i  in  8  network ingress byte.
REQ-013 net_valid_i  in  1  ingress byte valid.
REQ-014 net_ready_o  out  1  ingress ready; transfer when net_valid_i and net_ready_o both high.
REQ-015 connected_o  out  1  level, high while session established.
REQ-016 connected_host_addr_o  out  2  host index of established session.
REQ-017 refused_o  out  1  one-cycle pulse, connect to unavailable host.
REQ-018 message_o  out  8  byte delivered to engine.
REQ-019 valid_o  out  1  message_o valid, one cycle per byte.
REQ-020 new_message_o  out  1  high with first byte of each FIX message.
REQ-021 tx_byte_count_o  out  16  engine bytes accepted this session, saturating.
REQ-022 tx_field_count_o  out  8  SOH (0x01) bytes accepted this session, saturating.

Function
REQ-023 FSM states IDLE, HANDSHAKE, CONNECTED, CLOSING; all outputs registered.
REQ-024 IDLE: connect_req_i with host_up_i[connect_addr_i]=1 -> latch address, load counter CONNECT_LATENCY-1, clear both tx counters, go HANDSHAKE.
REQ-025 IDLE: connect_req_i with host_up_i[connect_addr_i]=0 -> refused_o high next cycle for exactly one cycle, stay IDLE.
REQ-026 HANDSHAKE: counter decrements each cycle; at zero -> CONNECTED; connected_o rises exactly CONNECT_LATENCY cycles after request edge; connect_req_i and disconnect_i ignored.
REQ-027 CONNECTED: connected_o=1, connected_host_addr_o=latched address; connect_req_i ignored.
REQ-028 CONNECTED: disconnect_i with disconnect_host_num_i equal to latched address -> CLOSING; mismatched host ignored.
REQ-029 CLOSING: one cycle; connected_o=0, valid_o=0, FIFO flushed; next state IDLE; tx counters hold values.
REQ-030 net_ready_o = CONNECTED and FIFO not full; ingress bytes never accepted in other states.
REQ-031 CONNECTED and FIFO non-empty: pop one byte per cycle onto message_o with valid_o=1; minimum latency one cycle from ingress acceptance to valid_o.
REQ-032 Simultaneous push and pop permitted at any occupancy below full; occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-033 new_message_o=1 on a delivered byte when it is the first byte since reset/session start or the previously delivered byte was 0x01.
REQ-034 CONNECTED: each send_message_valid_i cycle increments tx_byte_count_o; byte 0x01 also increments tx_field_count_o; both saturate (0xFFFF, 0xFF), no wrap; ignored outside CONNECTED.
REQ-035 disconnect_i in same cycle as a pop: byte still delivered; FIFO flush takes effect in CLOSING.

Reset
REQ-036 rst low: immediately state IDLE, FIFO empty, all outputs 0 (counters 0, connected_host_addr_o 0), regardless of clock.
REQ-037 Reset mid-HANDSHAKE or mid-CONNECTED abandons session; no refused_o pulse, no byte emitted after release until a new connection completes.

Verification
REQ-038 host_up_i=4'b0001, connect_req_i addr 0 -> connected_o=1, connected_host_addr_o=0 exactly 3 cycles later; connect_req_i addr 2 while connected -> ignored.
REQ-039 host_up_i=4'b0001, connect_req_i addr 3 -> refused_o one-cycle pulse, connected_o stays 0.
REQ-040 Connected; push "8=FIX" 0x01 "9=5" 0x01 back-to-back -> 10 bytes in order on message_o, new_message_o on bytes 1 and 7 only.
REQ-041 Connected; 20 ingress bytes with no pop stall impossible -> verify net_ready_o never low under steady 1/cycle; with FIFO forced full (disconnect pending test) net_ready_o=0 at 16 entries.
REQ-042 Connected; engine sends 300 bytes incl. 12 SOH -> tx_byte_count_o=300, tx_field_count_o=12; disconnect host 1 ignored; disconnect host 0 -> connected_o=0 after 1 cycle, counters held.
REQ-043 Assert rst low mid-HANDSHAKE and mid-stream -> all outputs 0 asynchronously; after release, no output activity until new connect.

Source files
------------

// File: rtl/fix_toe_responder_if.sv
// Signal bundle between the FIX engine / network side and the TOE responder.
// The slave view belongs to the responder, the master view to whoever drives it.
interface fix_toe_responder_if;
  logic       connect_req_i;
  logic [1:0] connect_addr_i;
  logic       disconnect_i;
  logic [1:0] disconnect_host_num_i;
  logic       send_message_valid_i;
  logic [7:0] send_message_i;
  logic [3:0] host_up_i;
  logic [7:0] net_data_i;
  logic       net_valid_i;
  logic       net_ready_o;
  logic       connected_o;
  logic [1:0] connected_host_addr_o;
  logic       refused_o;
  logic [7:0] message_o;
  logic       valid_o;
  logic       new_message_o;
  logic [15:0] tx_byte_count_o;
  logic [7:0]  tx_field_count_o;

  modport slave (
    input  connect_req_i, connect_addr_i, disconnect_i, disconnect_host_num_i,
           send_message_valid_i, send_message_i, host_up_i, net_data_i, net_valid_i,
    output net_ready_o, connected_o, connected_host_addr_o, refused_o, message_o,
           valid_o, new_message_o, tx_byte_count_o, tx_field_count_o
  );

  modport master (
    output connect_req_i, connect_addr_i, disconnect_i, disconnect_host_num_i,
           send_message_valid_i, send_message_i, host_up_i, net_data_i, net_valid_i,
    input  net_ready_o, connected_o, connected_host_addr_o, refused_o, message_o,
           valid_o, new_message_o, tx_byte_count_o, tx_field_count_o
  );
endinterface

// File: rtl/fix_toe_responder.sv
// TCP-offload session responder: connect/handshake/close FSM, ingress byte FIFO
// toward the FIX engine, and per-session outbound byte/field counters.
module fix_toe_responder #(
  parameter int CONNECT_LATENCY = 3,
  parameter int FIFO_DEPTH      = 16
) (
  input logic clk,
  input logic rst_n,
  fix_toe_responder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HANDSHAKE, CONNECTED, CLOSING} state_t;

  state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    addr_q, addr_d;
  logic          connected_q, connected_d;
  logic [1:0]    hostAddr_q, hostAddr_d;
  logic          refused_q, refused_d;
  logic          valid_q, valid_d;
  logic [7:0]    message_q, message_d;
  logic          newMsg_q, newMsg_d;
  logic          firstByte_q, firstByte_d;
  logic [15:0]   txBytes_q, txBytes_d;
  logic [7:0]    txFields_q, txFields_d;
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          netReady, push, pop, flush;
  logic [7:0]    headByte;

  assign netReady = (state_q == CONNECTED) && (count_q != FULL);
  assign push     = bus.net_valid_i && netReady;
  assign pop      = (state_q == CONNECTED) && (count_q != '0);
  assign headByte = mem[rdPtr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    connected_d = connected_q;
    hostAddr_d  = hostAddr_q;
    refused_d   = 1'b0;
    valid_d     = 1'b0;
    message_d   = message_q;
    newMsg_d    = 1'b0;
    firstByte_d = firstByte_q;
    txBytes_d   = txBytes_q;
    txFields_d  = txFields_q;
    flush       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.connect_req_i) begin
          if (bus.host_up_i[bus.connect_addr_i]) begin
            state_d     = HANDSHAKE;
            addr_d      = bus.connect_addr_i;
            cnt_d       = 4'(CONNECT_LATENCY - 1);
            txBytes_d   = '0;
            txFields_d  = '0;
            firstByte_d = 1'b1;
          end else begin
            refused_d = 1'b1;
          end
        end
      end
      HANDSHAKE: begin
        if (cnt_q == '0) begin
          state_d     = CONNECTED;
          connected_d = 1'b1;
          hostAddr_d  = addr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CONNECTED: begin
        // A byte popped in the same cycle as a disconnect is still delivered.
        if (pop) begin
          valid_d     = 1'b1;
          message_d   = headByte;
          newMsg_d    = firstByte_q;
          firstByte_d = (headByte == 8'h01);
        end
        if (bus.send_message_valid_i) begin
          if (txBytes_q != 16'hFFFF) txBytes_d = txBytes_q + 16'd1;
          if (bus.send_message_i == 8'h01 && txFields_q != 8'hFF)
            txFields_d = txFields_q + 8'd1;
        end
        if (bus.disconnect_i && bus.disconnect_host_num_i == addr_q) begin
          state_d     = CLOSING;
          connected_d = 1'b0;
          hostAddr_d  = '0;
        end
      end
      CLOSING: begin
        flush   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      connected_q <= 1'b0;
      hostAddr_q  <= '0;
      refused_q   <= 1'b0;
      valid_q     <= 1'b0;
      message_q   <= '0;
      newMsg_q    <= 1'b0;
      firstByte_q <= 1'b1;
      txBytes_q   <= '0;
      txFields_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      connected_q <= connected_d;
      hostAddr_q  <= hostAddr_d;
      refused_q   <= refused_d;
      valid_q     <= valid_d;
      message_q   <= message_d;
      newMsg_q    <= newMsg_d;
      firstByte_q <= firstByte_d;
      txBytes_q   <= txBytes_d;
      txFields_q  <= txFields_d;
    end
  end

  // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= bus.net_data_i;
  end

  assign bus.net_ready_o           = netReady;
  assign bus.connected_o           = connected_q;
  assign bus.connected_host_addr_o = hostAddr_q;
  assign bus.refused_o             = refused_q;
  assign bus.message_o             = message_q;
  assign bus.valid_o               = valid_q;
  assign bus.new_message_o         = newMsg_q;
  assign bus.tx_byte_count_o       = txBytes_q;
  assign bus.tx_field_count_o      = txFields_q;
endmodule
